// File: rtl/uart_mmio_ctrl.sv
// UART controller on the core data bus.
// TX FIFO + 8N1 shifter, RX holding register, CTRL/STATUS words.
module uart_mmio_ctrl #(
  parameter int BAUD_DIV = 434,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_LIM = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LIM = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          tx_full, tx_empty, push, tx_pop;
  logic [1:0]    ctrl;
  logic          tx_en, rx_en;

  st_t           tx_st, tx_nx;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick, tx_busy;

  st_t           rx_st, rx_nx;
  logic [CW-1:0] rx_cnt, rx_lim;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_s1, rx_s2, rx_s3;
  logic          rx_tick, rx_fall, rx_deliver;
  logic [7:0]    rx_byte;
  logic          rx_valid, rx_overrun, rd_rx;

  logic unused_bits;
  assign unused_bits = ^{wdata[31:8], addr[1:0]};

  assign tx_en    = ctrl[0];
  assign rx_en    = ctrl[1];
  assign tx_full  = count == (AW+1)'(TX_DEPTH);
  assign tx_empty = count == '0;
  assign push     = we && addr[3:2] == 2'd0 && !tx_full;
  assign rd_rx    = re && addr[3:2] == 2'd1;
  assign tx_tick  = tx_cnt == FULL_LIM;
  assign tx_busy  = tx_st != IDLE;
  assign rx_fall  = rx_s3 && !rx_s2;
  assign rx_lim   = (rx_st == START) ? HALF_LIM : FULL_LIM;
  assign rx_tick  = rx_cnt == rx_lim;

  // FIFO storage needs no reset; occupancy lives in the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (tx_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(tx_pop);
    end
  end

  // CTRL register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctrl <= 2'b11;
    else if (we && addr[3:2] == 2'd3) ctrl <= wdata[1:0];
  end

  // TX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_st <= IDLE;
    else tx_st <= tx_nx;
  end

  // TX next state; tx_en only gates starting a new frame
  always_comb begin
    tx_nx  = tx_st;
    tx_pop = 1'b0;
    unique case (tx_st)
      IDLE: if (tx_en && !tx_empty) begin
        tx_pop = 1'b1;
        tx_nx  = START;
      end
      START: if (tx_tick) tx_nx = DATA;
      DATA: if (tx_tick && tx_bit == 3'd7) tx_nx = STOP;
      STOP: if (tx_tick) tx_nx = IDLE;
      default: tx_nx = IDLE;
    endcase
  end

  // TX bit timer and shifter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      if (tx_st == IDLE || tx_tick) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 1'b1;
      if (tx_pop) tx_sh <= mem[rptr];
      if (tx_st == START && tx_tick) tx_bit <= '0;
      if (tx_st == DATA && tx_tick) begin
        tx_bit <= tx_bit + 1'b1;
        tx_sh  <= tx_sh >> 1;
      end
    end
  end

  // Line level decoded from registered state, so reset forces idle at once
  always_comb begin
    uart_tx = 1'b1;
    unique case (tx_st)
      START: uart_tx = 1'b0;
      DATA: uart_tx = tx_sh[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // RX synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_st <= IDLE;
    else rx_st <= rx_nx;
  end

  // RX next state; dropping rx_en abandons any frame in flight
  always_comb begin
    rx_nx      = rx_st;
    rx_deliver = 1'b0;
    if (!rx_en) begin
      rx_nx = IDLE;
    end else begin
      unique case (rx_st)
        IDLE: if (rx_fall) rx_nx = START;
        START: if (rx_tick) rx_nx = rx_s2 ? IDLE : DATA;
        DATA: if (rx_tick && rx_bit == 3'd7) rx_nx = STOP;
        STOP: if (rx_tick) begin
          rx_nx      = IDLE;
          rx_deliver = rx_s2;
        end
        default: rx_nx = IDLE;
      endcase
    end
  end

  // RX sample timer and shifter, LSB arrives first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_st == IDLE || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_st == START && rx_tick) rx_bit <= '0;
      if (rx_st == DATA && rx_tick) begin
        rx_bit <= rx_bit + 1'b1;
        rx_sh  <= {rx_s2, rx_sh[7:1]};
      end
    end
  end

  // Holding register; a read in the delivery cycle makes room
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (we && addr[3:2] == 2'd2 && wdata[4]) rx_overrun <= 1'b0;
      if (rx_deliver && (!rx_valid || rd_rx)) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else begin
        if (rd_rx) rx_valid <= 1'b0;
        if (rx_deliver) rx_overrun <= 1'b1;
      end
    end
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    unique case (addr[3:2])
      2'd1: rdata = {24'b0, rx_byte};
      2'd2: rdata = {27'b0, rx_overrun, rx_valid,
                     tx_busy, tx_full, tx_empty};
      2'd3: rdata = {30'b0, ctrl};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: directed steps plus random bytes.
// A line decoder and byte queues act as the reference.
module tb_uart_mmio_ctrl;

  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BD + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mon_q[$];
  logic [7:0] exp_q[$];
  logic       m_bad;
  logic [7:0] m_b;

  uart_mmio_ctrl #(.BAUD_DIV(BD), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Independent 8N1 decoder on uart_tx, sampling mid-bit
  always begin
    @(negedge clk);
    if (!reset && uart_tx === 1'b0) begin
      m_bad = 1'b0;
      m_b   = '0;
      for (int j = 1; j <= 9 * BD + BD / 2; j++) begin
        @(negedge clk);
        if (reset) m_bad = 1'b1;
        if (j == BD / 2 && uart_tx !== 1'b0) m_bad = 1'b1;
        if (j >= BD + BD / 2 && j <= 8 * BD + BD / 2 && (j - BD / 2) % BD == 0)
          m_b[(j - BD / 2) / BD - 1] = uart_tx;
        if (j == 9 * BD + BD / 2 && uart_tx !== 1'b1) m_bad = 1'b1;
      end
      if (!m_bad) mon_q.push_back(m_b);
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_chk(string tag, logic [3:0] a, logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic pop_rx();
    @(negedge clk);
    re = 1'b1;
    addr = 4'h4;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic send_rx(logic [7:0] b, logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    cyc(BD);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cyc(BD);
    end
    uart_rx = stop;
    cyc(BD);
    uart_rx = 1'b1;
    cyc(BD + 4);
  endtask

  function automatic logic frame_bit(logic [7:0] b, int k);
    if (k < BD) return 1'b0;
    if (k < 9 * BD) return b[(k - BD) / BD];
    return 1'b1;
  endfunction

  task automatic drain_chk(string tag);
    chk({tag, "_n"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk({tag, "_b"}, mon_q[i], exp_q[i]);
    mon_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rb;
    int n, busy, lows;
    logic [31:0] es;

    // Reset state
    cyc(1);
    #1 chk("rst_tx_in", uart_tx, 1);
    cyc(2);
    reset = 1'b0;
    #1 chk("rst_tx", uart_tx, 1);
    rd_chk("rst_status", 4'h8, 32'h01);
    rd_chk("rst_ctrl", 4'hC, 32'h3);
    rd_chk("rst_rxdata", 4'h4, 32'h0);
    rd_chk("rd_txdata", 4'h0, 32'h0);

    // CTRL keeps only two bits
    wr(4'hC, 32'hFFFF_FFFD);
    rd_chk("ctrl_mask", 4'hC, 32'h1);
    wr(4'hC, 32'h3);

    // Single frame: exact line waveform and busy length
    wr(4'h0, 32'h55);
    addr = 4'h8;
    busy = 0;
    for (int i = 0; i < 45; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("t2_line", uart_tx,
          (i >= 1 && i <= 10 * BD) ? frame_bit(8'h55, i - 1) : 1'b1);
      busy += int'(rdata[2]);
    end
    chk("t2_busy", busy, 10 * BD);
    rd_chk("t2_status", 4'h8, 32'h01);
    exp_q.push_back(8'h55);
    drain_chk("t2");

    // Fill with TX disabled, overflow dropped
    wr(4'hC, 32'h2);
    for (int i = 1; i <= 5; i++) begin
      wr(4'h0, 32'(i * 8'h11));
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i * 8'h11));
    end
    rd_chk("t3_full", 4'h8, 32'h02);
    wr(4'hC, 32'h3);
    cyc(DEPTH * FRAME + 20);
    drain_chk("t3");

    // Random fill depths and bytes
    for (int r = 0; r < 3; r++) begin
      wr(4'hC, 32'h2);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        rb = 8'($urandom);
        wr(4'h0, {24'b0, rb});
        if (exp_q.size() < DEPTH) exp_q.push_back(rb);
      end
      es = (exp_q.size() == DEPTH) ? 32'h02 : 32'h00;
      rd_chk("t3r_status", 4'h8, es);
      wr(4'hC, 32'h3);
      cyc(exp_q.size() * FRAME + 20);
      drain_chk("t3r");
    end

    // Receive one frame
    send_rx(8'hA3, 1'b1);
    rd_chk("t4_status", 4'h8, 32'h09);
    rd_chk("t4_data", 4'h4, 32'hA3);
    pop_rx();
    rd_chk("t4_clear", 4'h8, 32'h01);

    // Random receive
    for (int r = 0; r < 4; r++) begin
      rb = 8'($urandom);
      send_rx(rb, 1'b1);
      rd_chk("rxr_status", 4'h8, 32'h09);
      rd_chk("rxr_data", 4'h4, {24'b0, rb});
      pop_rx();
    end

    // Overrun keeps the first byte
    send_rx(8'h01, 1'b1);
    send_rx(8'h02, 1'b1);
    rd_chk("t5_data", 4'h4, 32'h01);
    rd_chk("t5_ovr", 4'h8, 32'h19);
    wr(4'h8, 32'h10);
    rd_chk("t5_ovr_clr", 4'h8, 32'h09);
    pop_rx();
    rd_chk("t5_empty", 4'h8, 32'h01);

    // Framing error is dropped without a flag
    send_rx(8'h5A, 1'b0);
    rd_chk("ferr_status", 4'h8, 32'h01);

    // Reset in the middle of a frame
    wr(4'h0, 32'hFF);
    cyc(3);
    #1 chk("t6_start_low", uart_tx, 0);
    cyc(7);
    reset = 1'b1;
    #1 chk("t6_tx_async", uart_tx, 1);
    cyc(3);
    reset = 1'b0;
    rd_chk("t6_status", 4'h8, 32'h01);
    rd_chk("t6_ctrl", 4'hC, 32'h3);
    lows = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      #1 lows += int'(!uart_tx);
    end
    chk("t6_no_frame", lows, 0);
    drain_chk("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
